led_fade_pwm: RTL and testbench

//   Downstream stage of the RGB colour-step counter. Consumes its three active-low on/off

---
 rtl/led_fade_pwm.sv | 127 ++++++++++++
 tb/tb_led_fade_pwm.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_fade_pwm.sv
// led_fade_pwm
//   Takes the three active-low colour levels from the colour-step counter and drives the RGB
//   LED pins with active-low PWM. Each channel's brightness ramps toward its requested level
//   (fully on or fully off) in fixed steps, one step per fade tick, instead of switching hard.
//
// Parameters
//   PWM_BITS  brightness level and PWM counter width; MAX = 2**PWM_BITS-1
//   FADE_DIV  clocks per fade tick (>= 1)
//   STEP      level change per fade tick (1..MAX)
//
// Ports
//   clk       system clock, all logic on the rising edge
//   rst_n     asynchronous active-low reset
//   red_in    requested red state, active-low (0 = on)
//   green_in  requested green state, active-low
//   blue_in   requested blue state, active-low
//   red       red LED pin, active-low PWM (0 = lit)
//   green     green LED pin, active-low PWM
//   blue      blue LED pin, active-low PWM
//   settled   1 when every channel's level and duty have reached its target
module led_fade_pwm #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned FADE_DIV = 1000,
  parameter int unsigned STEP     = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic red_in,
  input  logic green_in,
  input  logic blue_in,
  output logic red,
  output logic green,
  output logic blue,
  output logic settled
);

  localparam int unsigned MAX   = 2**PWM_BITS - 1;
  localparam int unsigned DIV_W = $clog2(FADE_DIV + 1);

  localparam logic [PWM_BITS-1:0] MaxLvl    = PWM_BITS'(MAX);
  localparam logic [PWM_BITS-1:0] PwmLast   = PWM_BITS'(MAX - 1);
  localparam logic [PWM_BITS:0]   StepW     = (PWM_BITS + 1)'(STEP);
  localparam logic [DIV_W-1:0]    PrescLast = DIV_W'(FADE_DIV - 1);

  // Ramp direction; it is a pure function of the registered request, so the ramp reacts
  // on the very next tick after the request changes.
  typedef enum logic {StDown, StUp} dir_e;

  // Channel index 0 = red, 1 = green, 2 = blue.
  logic [2:0]                 in_q;
  logic [DIV_W-1:0]           presc_q, presc_d;
  logic [PWM_BITS-1:0]        pwm_q, pwm_d;
  logic [2:0][PWM_BITS-1:0]   level_q, level_d;
  logic [2:0][PWM_BITS-1:0]   duty_q, duty_d;
  logic [2:0][PWM_BITS-1:0]   target;
  logic [2:0]                 pin_q, pin_d;
  logic                       settled_q, settled_d;
  logic                       fade_tick;
  logic                       pwm_wrap;
  logic [PWM_BITS:0]          sum;
  dir_e                       dir;

  always_comb begin
    fade_tick = (presc_q == PrescLast);
    presc_d   = fade_tick ? '0 : presc_q + 1'b1;
    pwm_wrap  = (pwm_q == PwmLast);
    pwm_d     = pwm_wrap ? '0 : pwm_q + 1'b1;
    level_d   = level_q;
    duty_d    = duty_q;
    pin_d     = pin_q;
    target    = '0;
    settled_d = 1'b1;
    sum       = '0;
    dir       = StDown;

    for (int i = 0; i < 3; i++) begin
      target[i] = in_q[i] ? '0 : MaxLvl;
      dir       = in_q[i] ? StDown : StUp;
      // One extra bit so the upward step can be clamped instead of wrapping.
      sum       = {1'b0, level_q[i]} + StepW;

      if (fade_tick) begin
        unique case (dir)
          StUp:   level_d[i] = (sum > {1'b0, MaxLvl}) ? MaxLvl : sum[PWM_BITS-1:0];
          StDown: level_d[i] = ({1'b0, level_q[i]} < StepW) ? '0
                                                             : level_q[i] - StepW[PWM_BITS-1:0];
          default: level_d[i] = level_q[i];
        endcase
      end

      // Shadow takes the current (pre-tick) level on the last count of the period, so a new
      // duty always starts on a full period and no runt pulse is produced.
      if (pwm_wrap) begin
        duty_d[i] = level_q[i];
      end

      pin_d[i]  = ~(pwm_q < duty_q[i]);
      settled_d = settled_d & (level_q[i] == target[i]) & (duty_q[i] == level_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q      <= 3'b111;
      presc_q   <= '0;
      pwm_q     <= '0;
      level_q   <= '0;
      duty_q    <= '0;
      pin_q     <= 3'b111;
      settled_q <= 1'b1;
    end else begin
      in_q      <= {blue_in, green_in, red_in};
      presc_q   <= presc_d;
      pwm_q     <= pwm_d;
      level_q   <= level_d;
      duty_q    <= duty_d;
      pin_q     <= pin_d;
      settled_q <= settled_d;
    end
  end

  assign red     = pin_q[0];
  assign green   = pin_q[1];
  assign blue    = pin_q[2];
  assign settled = settled_q;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Scoreboard bench for led_fade_pwm. Stimulus pushes cycle-tagged expected pin/settled values
// into a queue; a monitor on the falling edge pops and compares every entry that falls due.
// Cycle k of a test is the k-th rising edge after reset release.
module tb_led_fade_pwm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic red_in = 1'b1;
  logic green_in = 1'b1;
  logic blue_in = 1'b1;

  logic m_red, m_green, m_blue, m_settled;
  logic s_red, s_green, s_blue, s_settled;
  logic q_red, q_green, q_blue, q_settled;

  // Main: bench parameters. Slow: long fade period so a mid level is held for many periods.
  // Step4: STEP=4 saturation run.
  led_fade_pwm #(.PWM_BITS(4), .FADE_DIV(4), .STEP(1)) u_main (
    .clk(clk), .rst_n(rst_n), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .red(m_red), .green(m_green), .blue(m_blue), .settled(m_settled)
  );
  led_fade_pwm #(.PWM_BITS(4), .FADE_DIV(200), .STEP(1)) u_slow (
    .clk(clk), .rst_n(rst_n), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .red(s_red), .green(s_green), .blue(s_blue), .settled(s_settled)
  );
  led_fade_pwm #(.PWM_BITS(4), .FADE_DIV(4), .STEP(4)) u_step4 (
    .clk(clk), .rst_n(rst_n), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .red(q_red), .green(q_green), .blue(q_blue), .settled(q_settled)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    int unsigned sig;
    logic        val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  localparam int unsigned MRed = 0, MGreen = 1, MBlue = 2, MSet = 3;
  localparam int unsigned SRed = 4, QRed = 8;

  function automatic logic probe(int unsigned s);
    case (s)
      0: return m_red;
      1: return m_green;
      2: return m_blue;
      3: return m_settled;
      4: return s_red;
      5: return s_green;
      6: return s_blue;
      7: return s_settled;
      8: return q_red;
      9: return q_green;
      10: return q_blue;
      11: return q_settled;
      default: return 1'bx;
    endcase
  endfunction

  function automatic void push(int unsigned c, int unsigned s, logic v, string nm);
    exp_t e;
    e.cyc  = c;
    e.sig  = s;
    e.val  = v;
    e.name = nm;
    sb.push_back(e);
  endfunction

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_total++;
      if (e.cyc < cyc) begin
        $display("FAIL %s: not sampled at cycle %0d (now %0d), required %b",
                 e.name, e.cyc, cyc, e.val);
      end else if (probe(e.sig) !== e.val) begin
        $display("FAIL %s @%0d: got %b, required %b", e.name, cyc, probe(e.sig), e.val);
      end else begin
        n_pass++;
      end
    end
  end

  task automatic wait_cyc(int unsigned t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic r, input logic g, input logic b,
                          output int unsigned base);
    @(posedge clk);
    #1;
    rst_n    = 1'b0;
    red_in   = r;
    green_in = g;
    blue_in  = b;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base  = cyc;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d checks still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base;
    logic [2:0] pat [6];
    pat = '{3'b000, 3'b101, 3'b010, 3'b110, 3'b001, 3'b011};

    // 1: inputs toggling under reset, then idle after release.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    base  = cyc;
    for (int k = 1; k <= 6; k++) begin
      push(base + k, MRed,   1'b1, $sformatf("t1 rst red k%0d", k));
      push(base + k, MGreen, 1'b1, $sformatf("t1 rst green k%0d", k));
      push(base + k, MBlue,  1'b1, $sformatf("t1 rst blue k%0d", k));
      push(base + k, MSet,   1'b1, $sformatf("t1 rst settled k%0d", k));
    end
    for (int i = 0; i < 6; i++) begin
      {blue_in, green_in, red_in} = pat[i];
      @(posedge clk);
      #1;
    end
    {blue_in, green_in, red_in} = 3'b111;
    rst_n = 1'b1;
    base  = cyc;
    for (int k = 1; k <= 12; k++) begin
      push(base + k, MRed,   1'b1, $sformatf("t1 idle red k%0d", k));
      push(base + k, MGreen, 1'b1, $sformatf("t1 idle green k%0d", k));
      push(base + k, MBlue,  1'b1, $sformatf("t1 idle blue k%0d", k));
      push(base + k, MSet,   1'b1, $sformatf("t1 idle settled k%0d", k));
    end
    drain();

    // 2: full ramp up; duty reaches 15 at cycle 75, settled from cycle 76.
    do_reset(1'b0, 1'b1, 1'b1, base);
    push(base + 1,  MSet, 1'b1, "t2 settled k1");
    push(base + 2,  MSet, 1'b0, "t2 settled k2");
    push(base + 75, MSet, 1'b0, "t2 settled k75");
    push(base + 76, MSet, 1'b1, "t2 settled k76");
    for (int k = 76; k <= 95; k++) push(base + k, MRed, 1'b0, $sformatf("t2 red lit k%0d", k));
    push(base + 95, MGreen, 1'b1, "t2 green dark");
    push(base + 95, MBlue,  1'b1, "t2 blue dark");
    drain();

    // 3: slow instance holds level 5; duty 4 period, then 5 of 15 lit, later duty 4.
    do_reset(1'b0, 1'b1, 1'b1, base);
    for (int k = 991; k <= 1065; k++) begin
      if (k <= 1005) push(base + k, SRed, ((k - 991) < 4) ? 1'b0 : 1'b1,
                          $sformatf("t3 duty4 red k%0d", k));
      else push(base + k, SRed, (((k - 1006) % 15) < 5) ? 1'b0 : 1'b1,
                $sformatf("t3 duty5 red k%0d", k));
    end
    for (int k = 1216; k <= 1230; k++)
      push(base + k, SRed, ((k - 1216) < 4) ? 1'b0 : 1'b1, $sformatf("t3 down4 red k%0d", k));
    wait_cyc(base + 1100);
    red_in = 1'b1;
    drain();

    // 4: reverse at level 8; duties 7, 5, 2, then 0.
    do_reset(1'b0, 1'b1, 1'b1, base);
    for (int k = 31; k <= 90; k++) begin
      logic v;
      if (k <= 45)      v = ((k - 31) < 7) ? 1'b0 : 1'b1;
      else if (k <= 60) v = ((k - 46) < 5) ? 1'b0 : 1'b1;
      else if (k <= 75) v = ((k - 61) < 2) ? 1'b0 : 1'b1;
      else              v = 1'b1;
      push(base + k, MRed, v, $sformatf("t4 red k%0d", k));
      if (k == 75) push(base + k, MSet, 1'b0, "t4 settled k75");
      if (k == 76) push(base + k, MSet, 1'b1, "t4 settled k76");
    end
    wait_cyc(base + 33);
    red_in = 1'b1;
    drain();

    // 5: STEP=4 instance; duties 12, 15 (saturated), 3, 0 (no wrap).
    do_reset(1'b0, 1'b1, 1'b1, base);
    for (int k = 16; k <= 75; k++) begin
      logic v;
      if (k <= 30)      v = ((k - 16) < 12) ? 1'b0 : 1'b1;
      else if (k <= 45) v = 1'b0;
      else if (k <= 60) v = ((k - 46) < 3) ? 1'b0 : 1'b1;
      else              v = 1'b1;
      push(base + k, QRed, v, $sformatf("t5 step4 red k%0d", k));
    end
    wait_cyc(base + 33);
    red_in = 1'b1;
    drain();

    // 6: async reset mid-ramp (green level 9, pwm_cnt 6) between edges.
    do_reset(1'b1, 1'b0, 1'b1, base);
    push(base + 35, MGreen, 1'b0, "t6 green lit before reset");
    push(base + 36, MGreen, 1'b1, "t6 green async dark");
    push(base + 36, MSet,   1'b1, "t6 settled async");
    push(base + 36, MRed,   1'b1, "t6 red async dark");
    wait_cyc(base + 36);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    green_in = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    base  = cyc;
    for (int k = 1; k <= 10; k++) begin
      push(base + k, MGreen, 1'b1, $sformatf("t6 post green k%0d", k));
      push(base + k, MSet,   1'b1, $sformatf("t6 post settled k%0d", k));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
